// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and types for the pipeline hazard/flow controller
// Contents:
//   ADDR_W, MEM_CODE_W     : bus widths seen by pipe_ctrl
//   MEM_CODE_*             : data-memory response codes
//   mem_state_e            : 2-bit memory wait FSM encoding
//   DEF_*                  : default pipeline geometry (FE=0 .. WB=4)
package pipe_ctrl_pkg;

   localparam int ADDR_W     = 32;
   localparam int MEM_CODE_W = 2;

   localparam logic [MEM_CODE_W-1:0] MEM_CODE_IDLE = 2'd0;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_BUSY = 2'd1;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_DONE = 2'd2;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_ERR  = 2'd3;

   typedef enum logic [1:0] {
      MEM_IDLE  = 2'd0,
      MEM_WAIT  = 2'd1,
      MEM_FAULT = 2'd2
   } mem_state_e;

   localparam int DEF_STAGES   = 5;
   localparam int DEF_ID_STAGE = 1;
   localparam int DEF_EX_STAGE = 2;
   localparam int DEF_ME_STAGE = 3;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
// Ports:
//   clk   : clock
//   clr   : synchronous active-high clear
//   en    : count this cycle
//   count : current value, saturates at 2^WIDTH-1
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - per-stage valid/stall/clear generation for the in-order pipeline
// Ports:
//   clk, clr                         : clock, synchronous active-high reset
//   i_fetch_valid                    : FE presents an instruction
//   i_load_use                       : ID load-use hazard
//   i_branch_taken, i_branch_addr    : EX resolved taken branch and its target
//   i_mem_req, i_mem_code            : data-memory response status for the ME instruction
//   o_stall, o_clr, o_valid          : per-stage hold, bubble and occupancy
//   o_redirect, o_redirect_addr      : FE PC load
//   o_fault                          : sticky memory fault
//   o_retired, o_stall_cycles        : saturating performance counters
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int STAGES      = DEF_STAGES,
   parameter int ID_STAGE    = DEF_ID_STAGE,
   parameter int EX_STAGE    = DEF_EX_STAGE,
   parameter int ME_STAGE    = DEF_ME_STAGE,
   parameter int IMEM_LAT    = 1,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  i_fetch_valid,
   input  logic                  i_load_use,
   input  logic                  i_branch_taken,
   input  logic [ADDR_W-1:0]     i_branch_addr,
   input  logic                  i_mem_req,
   input  logic [MEM_CODE_W-1:0] i_mem_code,
   output logic [STAGES-1:0]     o_stall,
   output logic [STAGES-1:0]     o_clr,
   output logic [STAGES-1:0]     o_valid,
   output logic                  o_redirect,
   output logic [ADDR_W-1:0]     o_redirect_addr,
   output logic                  o_fault,
   output logic [CNT_W-1:0]      o_retired,
   output logic [CNT_W-1:0]      o_stall_cycles
);

   // wait counter holds up to MEM_TIMEOUT with headroom for the +1 compare
   localparam int CW = $clog2(MEM_TIMEOUT) + 2;
   localparam logic [3:0] SHADOW_LOAD = 4'(IMEM_LAT);

   mem_state_e        state_q, state_n;
   logic [CW-1:0]     cnt_q, cnt_n;
   logic              mem_stall;
   logic              do_fault, do_branch;
   logic [3:0]        shadow_q;
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] shifted;
   logic              fetch_ok;
   logic              mem_start;

   assign mem_start = i_mem_req && valid_q[EX_STAGE];

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= MEM_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
      end
   end

   // the stall is raised in the same cycle BUSY is first seen, and dropped
   // in the same cycle DONE arrives, so the FSM only tracks the cycles between
   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      mem_stall = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            if (mem_start && (i_mem_code == MEM_CODE_BUSY)) begin
               state_n   = MEM_WAIT;
               cnt_n     = CW'(1);
               mem_stall = 1'b1;
            end else if (mem_start && (i_mem_code == MEM_CODE_ERR)) begin
               state_n = MEM_FAULT;
            end
         end
         MEM_WAIT: begin
            if (i_mem_code == MEM_CODE_DONE) begin
               state_n = MEM_IDLE;
               cnt_n   = '0;
            end else begin
               mem_stall = 1'b1;
               if ((i_mem_code == MEM_CODE_ERR) ||
                   ((cnt_q + CW'(1)) >= CW'(MEM_TIMEOUT))) begin
                  state_n = MEM_FAULT;
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end
         end
         MEM_FAULT: begin
            state_n = MEM_FAULT;
         end
         default: begin
            state_n = MEM_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   assign do_fault  = (state_q == MEM_FAULT);
   assign do_branch = i_branch_taken && valid_q[ID_STAGE] && !mem_stall && !do_fault;

   // stall masks are prefixes; the first unstalled stage gets a bubble
   always_comb begin
      o_stall    = '0;
      o_clr      = '0;
      o_redirect = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         if (do_fault) begin
            o_stall[k] = 1'b1;
         end else if (mem_stall) begin
            o_stall[k] = (k <= ME_STAGE);
            o_clr[k]   = (k == ME_STAGE + 1);
         end else if (do_branch) begin
            o_clr[k] = (k >= ID_STAGE) && (k < EX_STAGE);
         end else if (i_load_use) begin
            o_stall[k] = (k <= ID_STAGE);
            o_clr[k]   = (k == ID_STAGE + 1);
         end
      end
      o_redirect = do_branch;
      if (clr) begin
         o_stall    = '0;
         o_clr      = '1;
         o_redirect = 1'b0;
      end
   end

   assign o_redirect_addr = i_branch_addr;
   assign o_fault         = do_fault;

   // fetch data still in flight from the old PC is dropped while shadow != 0
   always_ff @(posedge clk) begin
      if (clr) begin
         shadow_q <= '0;
      end else if (do_branch) begin
         shadow_q <= SHADOW_LOAD;
      end else if (shadow_q != 4'd0) begin
         shadow_q <= shadow_q - 4'd1;
      end
   end

   assign fetch_ok = i_fetch_valid && (shadow_q == 4'd0);
   assign shifted  = {valid_q[STAGES-2:0], fetch_ok};

   always_ff @(posedge clk) begin
      if (clr) begin
         valid_q <= '0;
      end else begin
         valid_q <= ~o_clr & ((o_stall & valid_q) | (~o_stall & shifted));
      end
   end

   assign o_valid = valid_q;

   sat_counter #(.WIDTH(CNT_W)) u_retired (
      .clk   (clk),
      .clr   (clr),
      .en    (valid_q[STAGES-1]),
      .count (o_retired)
   );

   sat_counter #(.WIDTH(CNT_W)) u_stall_cycles (
      .clk   (clk),
      .clr   (clr),
      .en    (o_stall[0]),
      .count (o_stall_cycles)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int S_STALL = 0;
   localparam int S_CLR   = 1;
   localparam int S_VALID = 2;
   localparam int S_REDIR = 3;
   localparam int S_RADDR = 4;
   localparam int S_FAULT = 5;
   localparam int S_RET   = 6;
   localparam int S_STC   = 7;

   logic                  clk = 1'b0;
   logic                  clr;
   logic                  fetch_valid, load_use, branch_taken, mem_req;
   logic [ADDR_W-1:0]     branch_addr;
   logic [MEM_CODE_W-1:0] mem_code;
   logic [4:0]            stall, clrv, valid;
   logic                  redirect, fault;
   logic [ADDR_W-1:0]     redirect_addr;
   logic [3:0]            retired, stall_cycles;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      int          sel;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pipe_ctrl #(
      .STAGES(5), .ID_STAGE(1), .EX_STAGE(2), .ME_STAGE(3),
      .IMEM_LAT(1), .MEM_TIMEOUT(16), .CNT_W(4)
   ) dut (
      .clk             (clk),
      .clr             (clr),
      .i_fetch_valid   (fetch_valid),
      .i_load_use      (load_use),
      .i_branch_taken  (branch_taken),
      .i_branch_addr   (branch_addr),
      .i_mem_req       (mem_req),
      .i_mem_code      (mem_code),
      .o_stall         (stall),
      .o_clr           (clrv),
      .o_valid         (valid),
      .o_redirect      (redirect),
      .o_redirect_addr (redirect_addr),
      .o_fault         (fault),
      .o_retired       (retired),
      .o_stall_cycles  (stall_cycles)
   );

   function automatic logic [63:0] observe(int sel);
      case (sel)
         S_STALL: return 64'(stall);
         S_CLR:   return 64'(clrv);
         S_VALID: return 64'(valid);
         S_REDIR: return 64'(redirect);
         S_RADDR: return 64'(redirect_addr);
         S_FAULT: return 64'(fault);
         S_RET:   return 64'(retired);
         default: return 64'(stall_cycles);
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic want(input string tag, input int sel, input logic [63:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb.push_back(e);
   endtask

   // compare everything queued for this cycle at the falling edge, then move
   // just past the next rising edge to drive the following cycle
   task automatic cyc();
      exp_t e;
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.sel), e.exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      fetch_valid  = 1'b0;
      load_use     = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = '0;
      mem_req      = 1'b0;
      mem_code     = MEM_CODE_IDLE;
   endtask

   task automatic fill();
      clr = 1'b1;
      quiet();
      cyc();
      clr = 1'b0;
      fetch_valid = 1'b1;
      repeat (5) cyc();
   endtask

   initial begin
      clr = 1'b1;
      quiet();
      want("rst_stall", S_STALL, 64'h0);
      want("rst_clr",   S_CLR,   64'h1f);
      want("rst_valid", S_VALID, 64'h0);
      want("rst_fault", S_FAULT, 64'h0);
      want("rst_ret",   S_RET,   64'h0);
      want("rst_stc",   S_STC,   64'h0);
      want("rst_redir", S_REDIR, 64'h0);
      cyc();

      // load-use with a full pipe
      fill();
      want("fill_valid", S_VALID, 64'h1f);
      load_use = 1'b1;
      want("lu_stall", S_STALL, 64'h03);
      want("lu_clr",   S_CLR,   64'h04);
      cyc();
      load_use = 1'b0;
      want("lu_valid_after", S_VALID, 64'h1b);
      want("lu_stc",         S_STC,   64'd1);
      want("lu_ret",         S_RET,   64'd1);
      want("lu_stall_after", S_STALL, 64'h0);
      cyc();

      // taken branch with one cycle of fetch shadow
      fill();
      branch_taken = 1'b1;
      branch_addr  = 32'h100;
      want("br_redir", S_REDIR, 64'h1);
      want("br_addr",  S_RADDR, 64'h100);
      want("br_clr",   S_CLR,   64'h02);
      want("br_stall", S_STALL, 64'h0);
      cyc();
      branch_taken = 1'b0;
      want("br_redir_off", S_REDIR, 64'h0);
      want("br_valid1",    S_VALID, 64'h1d);
      cyc();
      want("br_shadow_drop", S_VALID, 64'h1a);
      cyc();
      want("br_fetch_back", S_VALID, 64'h15);
      cyc();

      // branch and load-use together: branch wins
      fill();
      branch_taken = 1'b1;
      load_use     = 1'b1;
      branch_addr  = 32'h24;
      want("brlu_stall", S_STALL, 64'h0);
      want("brlu_redir", S_REDIR, 64'h1);
      want("brlu_addr",  S_RADDR, 64'h24);
      cyc();
      branch_taken = 1'b0;
      load_use     = 1'b0;
      want("brlu_stc", S_STC, 64'd0);
      cyc();

      // BUSY x3 then DONE, with a branch ignored mid-wait
      fill();
      mem_req  = 1'b1;
      mem_code = MEM_CODE_BUSY;
      want("mw1_stall", S_STALL, 64'h0f);
      want("mw1_clr",   S_CLR,   64'h10);
      cyc();
      branch_taken = 1'b1;
      branch_addr  = 32'h200;
      want("mw2_stall", S_STALL, 64'h0f);
      want("mw2_redir", S_REDIR, 64'h0);
      cyc();
      branch_taken = 1'b0;
      want("mw3_stall", S_STALL, 64'h0f);
      cyc();
      mem_code = MEM_CODE_DONE;
      want("mw_done_stall", S_STALL, 64'h0);
      want("mw_done_clr",   S_CLR,   64'h0);
      cyc();
      mem_req      = 1'b0;
      mem_code     = MEM_CODE_IDLE;
      branch_taken = 1'b1;
      branch_addr  = 32'h300;
      want("mw_stc",      S_STC,   64'd3);
      want("mw_br_redir", S_REDIR, 64'h1);
      want("mw_br_addr",  S_RADDR, 64'h300);
      want("mw_idle_stall", S_STALL, 64'h0);
      cyc();
      branch_taken = 1'b0;

      // BUSY held until timeout
      fill();
      mem_req  = 1'b1;
      mem_code = MEM_CODE_BUSY;
      for (int i = 1; i <= 16; i++) begin
         if (i == 1 || i == 16) want("to_busy_stall", S_STALL, 64'h0f);
         want("to_busy_fault", S_FAULT, 64'h0);
         cyc();
      end
      mem_code     = MEM_CODE_DONE;
      branch_taken = 1'b1;
      branch_addr  = 32'h44;
      want("to_fault",     S_FAULT, 64'h1);
      want("to_stall_all", S_STALL, 64'h1f);
      want("to_clr",       S_CLR,   64'h0);
      want("to_redir",     S_REDIR, 64'h0);
      want("to_stc_sat",   S_STC,   64'hf);
      cyc();
      mem_req      = 1'b0;
      mem_code     = MEM_CODE_IDLE;
      branch_taken = 1'b0;
      repeat (2) begin
         want("to_fault_hold", S_FAULT, 64'h1);
         want("to_stall_hold", S_STALL, 64'h1f);
         cyc();
      end
      clr = 1'b1;
      want("to_clr_all",   S_CLR,   64'h1f);
      want("to_clr_stall", S_STALL, 64'h0);
      cyc();
      clr = 1'b0;
      fetch_valid = 1'b0;
      want("to_fault_gone", S_FAULT, 64'h0);
      want("to_stall_gone", S_STALL, 64'h0);
      want("to_valid_gone", S_VALID, 64'h0);
      cyc();

      // reset in the middle of a wait
      fill();
      mem_req  = 1'b1;
      mem_code = MEM_CODE_BUSY;
      repeat (2) begin
         want("cw_stall", S_STALL, 64'h0f);
         cyc();
      end
      clr = 1'b1;
      want("cw_clr",   S_CLR,   64'h1f);
      want("cw_stall0", S_STALL, 64'h0);
      want("cw_redir", S_REDIR, 64'h0);
      cyc();
      clr = 1'b0;
      quiet();
      want("cw_valid", S_VALID, 64'h0);
      want("cw_idle",  S_STALL, 64'h0);
      want("cw_stc",   S_STC,   64'h0);
      want("cw_ret",   S_RET,   64'h0);
      want("cw_fault", S_FAULT, 64'h0);
      cyc();

      // retire counter saturation at 4 bits
      fill();
      repeat (10) cyc();
      want("ret_10", S_RET, 64'd10);
      cyc();
      repeat (9) cyc();
      want("ret_sat", S_RET, 64'd15);
      want("ret_valid", S_VALID, 64'h1f);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
